// File: rtl/flexka_recursion_sequencer.sv
// rtl/flexka_recursion_sequencer.sv - Karatsuba split-tree walker with internal frame stack
// Emits leaf commands over valid/ready plus push/pop strobes for external per-level size stacks.
module flexka_recursion_sequencer #(
   parameter int  SSIZE     = 32,
   parameter int  MAX_DEPTH = 16,
   parameter int  LEAF_SIZE = 4,
   localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SSIZE-1:0] start_size_a,
   input  logic [SSIZE-1:0] start_size_b,
   output logic             busy,
   output logic             done,
   output logic             err_overflow,
   output logic             leaf_valid,
   input  logic             leaf_ready,
   output logic [SSIZE-1:0] leaf_size_a,
   output logic [SSIZE-1:0] leaf_size_b,
   output logic             push,
   output logic             pop,
   output logic [SSIZE-1:0] push_size_A2,
   output logic [SSIZE-1:0] push_size_B2,
   output logic [DW-1:0]    depth
);
   localparam int AW    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
   localparam int SLOTS = 1 << AW;

   localparam logic [1:0] C_LOW  = 2'd0;
   localparam logic [1:0] C_HIGH = 2'd1;
   localparam logic [1:0] C_MID  = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_EVAL, S_LEAF, S_ASCEND, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [SSIZE-1:0] cur_a_q, cur_a_d, cur_b_q, cur_b_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             err_q, err_d;

   logic [SSIZE-1:0] stk_a_q   [SLOTS];
   logic [SSIZE-1:0] stk_b_q   [SLOTS];
   logic [1:0]       stk_idx_q [SLOTS];

   logic             frm_we, idx_we;
   logic [1:0]       idx_wd;
   logic [AW-1:0]    top_ptr, push_ptr;

   function automatic logic [SSIZE-1:0] max2(input logic [SSIZE-1:0] x, input logic [SSIZE-1:0] y);
      return (x > y) ? x : y;
   endfunction

   // ceil(n/2) without forming n+1, so an all-ones size cannot wrap
   function automatic logic [SSIZE-1:0] half_up(input logic [SSIZE-1:0] n);
      return (n >> 1) + {{(SSIZE-1){1'b0}}, n[0]};
   endfunction

   function automatic logic [SSIZE-1:0] upper(input logic [SSIZE-1:0] x, input logic [SSIZE-1:0] h);
      return (x > h) ? x - h : '0;
   endfunction

   function automatic logic [SSIZE-1:0] lower(input logic [SSIZE-1:0] x, input logic [SSIZE-1:0] h);
      return (x < h) ? x : h;
   endfunction

   logic [SSIZE-1:0] cur_h, cur_a2, cur_b2, cur_la, cur_lb;
   logic             cur_is_leaf;
   logic [SSIZE-1:0] top_a, top_b, top_h, top_a2, top_b2, top_ma, top_mb;
   logic [1:0]       top_idx;

   assign top_ptr  = AW'(depth_q - DW'(1));
   assign push_ptr = AW'(depth_q);

   assign cur_h       = half_up(max2(cur_a_q, cur_b_q));
   assign cur_a2      = upper(cur_a_q, cur_h);
   assign cur_b2      = upper(cur_b_q, cur_h);
   assign cur_la      = lower(cur_a_q, cur_h);
   assign cur_lb      = lower(cur_b_q, cur_h);
   assign cur_is_leaf = max2(cur_a_q, cur_b_q) <= SSIZE'(LEAF_SIZE);

   // Children of the top frame are recomputed from its stored (a,b) instead of being stacked
   assign top_a   = stk_a_q[top_ptr];
   assign top_b   = stk_b_q[top_ptr];
   assign top_idx = stk_idx_q[top_ptr];
   assign top_h   = half_up(max2(top_a, top_b));
   assign top_a2  = upper(top_a, top_h);
   assign top_b2  = upper(top_b, top_h);
   assign top_ma  = (top_a2 != '0) ? top_h + SSIZE'(1) : lower(top_a, top_h);
   assign top_mb  = (top_b2 != '0) ? top_h + SSIZE'(1) : lower(top_b, top_h);

   always_comb begin
      state_d    = state_q;
      cur_a_d    = cur_a_q;
      cur_b_d    = cur_b_q;
      depth_d    = depth_q;
      err_d      = err_q;
      frm_we     = 1'b0;
      idx_we     = 1'b0;
      idx_wd     = C_LOW;
      push       = 1'b0;
      pop        = 1'b0;
      done       = 1'b0;
      leaf_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_a_d = start_size_a;
               cur_b_d = start_size_b;
               err_d   = 1'b0;
               depth_d = '0;
               state_d = (start_size_a == '0 || start_size_b == '0) ? S_DONE : S_EVAL;
            end
         end
         S_EVAL: begin
            if (cur_is_leaf) begin
               state_d = S_LEAF;
            end else if (depth_q == DW'(MAX_DEPTH)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               push    = 1'b1;
               frm_we  = 1'b1;
               depth_d = depth_q + DW'(1);
               cur_a_d = cur_la;
               cur_b_d = cur_lb;
            end
         end
         S_LEAF: begin
            leaf_valid = 1'b1;
            if (leaf_ready) state_d = S_ASCEND;
         end
         S_ASCEND: begin
            if (depth_q == '0) begin
               state_d = S_DONE;
            end else if (top_idx == C_LOW && top_a2 != '0 && top_b2 != '0) begin
               idx_we  = 1'b1;
               idx_wd  = C_HIGH;
               cur_a_d = top_a2;
               cur_b_d = top_b2;
               state_d = S_EVAL;
            end else if (top_idx != C_MID) begin
               idx_we  = 1'b1;
               idx_wd  = C_MID;
               cur_a_d = top_ma;
               cur_b_d = top_mb;
               state_d = S_EVAL;
            end else begin
               pop     = 1'b1;
               depth_d = depth_q - DW'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cur_a_q <= '0;
         cur_b_q <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_a_q <= cur_a_d;
         cur_b_q <= cur_b_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset
   always_ff @(posedge clk) begin
      if (frm_we) begin
         stk_a_q[push_ptr]   <= cur_a_q;
         stk_b_q[push_ptr]   <= cur_b_q;
         stk_idx_q[push_ptr] <= C_LOW;
      end else if (idx_we) begin
         stk_idx_q[top_ptr] <= idx_wd;
      end
   end

   assign busy         = (state_q == S_EVAL) || (state_q == S_LEAF) || (state_q == S_ASCEND);
   assign err_overflow = err_q;
   assign depth        = depth_q;
   assign leaf_size_a  = leaf_valid ? cur_a_q : '0;
   assign leaf_size_b  = leaf_valid ? cur_b_q : '0;
   assign push_size_A2 = push ? cur_a2 : '0;
   assign push_size_B2 = push ? cur_b2 : '0;

endmodule

// File: tb/tb_flexka_recursion_sequencer.sv
// tb/tb_flexka_recursion_sequencer.sv - bench for flexka_recursion_sequencer
// Reference walk is a pre-order traversal of the split tree using a node worklist.
module tb_flexka_recursion_sequencer;
   localparam int SSIZE = 32;
   localparam int LEAF  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             start;
   logic [SSIZE-1:0] start_size_a, start_size_b;
   logic             busy, done, err_overflow, leaf_valid, leaf_ready, push, pop;
   logic [SSIZE-1:0] leaf_size_a, leaf_size_b, push_size_A2, push_size_B2;
   logic [4:0]       depth;

   logic             s_start, s_busy, s_done, s_err, s_leaf_valid, s_leaf_ready, s_push, s_pop;
   logic [SSIZE-1:0] s_size_a, s_size_b, s_leaf_a, s_leaf_b, s_push_a, s_push_b;
   logic [0:0]       s_depth;

   flexka_recursion_sequencer #(.SSIZE(SSIZE), .MAX_DEPTH(16), .LEAF_SIZE(LEAF)) dut (
      .clk(clk), .rst(rst), .start(start), .start_size_a(start_size_a), .start_size_b(start_size_b),
      .busy(busy), .done(done), .err_overflow(err_overflow), .leaf_valid(leaf_valid),
      .leaf_ready(leaf_ready), .leaf_size_a(leaf_size_a), .leaf_size_b(leaf_size_b),
      .push(push), .pop(pop), .push_size_A2(push_size_A2), .push_size_B2(push_size_B2),
      .depth(depth));

   flexka_recursion_sequencer #(.SSIZE(SSIZE), .MAX_DEPTH(1), .LEAF_SIZE(LEAF)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .start_size_a(s_size_a), .start_size_b(s_size_b),
      .busy(s_busy), .done(s_done), .err_overflow(s_err), .leaf_valid(s_leaf_valid),
      .leaf_ready(s_leaf_ready), .leaf_size_a(s_leaf_a), .leaf_size_b(s_leaf_b),
      .push(s_push), .pop(s_pop), .push_size_A2(s_push_a), .push_size_B2(s_push_b),
      .depth(s_depth));

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [63:0] exp_leaf[$], exp_push[$], obs_leaf[$], obs_push[$];
   int          exp_pops, obs_pops, obs_done;
   int          s_leaves, s_pushes, s_pops, s_dones;
   logic [63:0] s_first_push;
   int          stall_mode = 0;

   // Reference: LOW, HIGH (skipped when either half is empty), MID, visited depth-first
   task automatic model(input int unsigned a0, input int unsigned b0);
      logic [63:0] work[$];
      logic [63:0] node;
      int unsigned a, b, n, h, a2, b2, la, lb;
      exp_leaf.delete();
      exp_push.delete();
      exp_pops = 0;
      if (a0 == 0 || b0 == 0) return;
      work.push_back({a0, b0});
      while (work.size() > 0) begin
         node = work.pop_back();
         a = node[63:32];
         b = node[31:0];
         n = (a > b) ? a : b;
         if (n <= LEAF) begin
            exp_leaf.push_back(node);
         end else begin
            h  = (n + 1) / 2;
            a2 = (a > h) ? a - h : 0;
            b2 = (b > h) ? b - h : 0;
            la = (a < h) ? a : h;
            lb = (b < h) ? b : h;
            exp_push.push_back({a2, b2});
            exp_pops++;
            work.push_back({(a2 != 0) ? h + 1 : la, (b2 != 0) ? h + 1 : lb});
            if (a2 != 0 && b2 != 0) work.push_back({a2, b2});
            work.push_back({la, lb});
         end
      end
   endtask

   logic        pv, pr;
   logic [63:0] prev_sz;
   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
         pr = 1'b0;
      end else begin
         if (leaf_valid && leaf_ready) obs_leaf.push_back({leaf_size_a, leaf_size_b});
         if (push) obs_push.push_back({push_size_A2, push_size_B2});
         if (pop) obs_pops++;
         if (done) obs_done++;
         if (push || pop) check("push_pop_exclusive", {71'd0, push & pop}, 72'd0);
         if (pv && !pr) check("leaf_hold", {7'd0, leaf_valid, leaf_size_a, leaf_size_b}, {7'd0, 1'b1, prev_sz});
         pv      = leaf_valid;
         pr      = leaf_ready;
         prev_sz = {leaf_size_a, leaf_size_b};
         if (s_leaf_valid && s_leaf_ready) s_leaves++;
         if (s_push) begin
            if (s_pushes == 0) s_first_push = {s_push_a, s_push_b};
            s_pushes++;
         end
         if (s_pop) s_pops++;
         if (s_done) s_dones++;
      end
   end

   initial begin : ready_drv
      int cnt;
      cnt        = 0;
      leaf_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode == 0) begin
            leaf_ready = 1'b1;
         end else if (stall_mode == 1) begin
            if (leaf_valid) begin
               cnt++;
               leaf_ready = (cnt > 5);
            end else begin
               cnt        = 0;
               leaf_ready = 1'b0;
            end
         end else begin
            leaf_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic begin_walk(input int unsigned a, input int unsigned b, input int mode);
      model(a, b);
      obs_leaf.delete();
      obs_push.delete();
      obs_pops   = 0;
      obs_done   = 0;
      stall_mode = mode;
      @(negedge clk);
      start_size_a = a;
      start_size_b = b;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_walk(input string tag, input int unsigned a, input int unsigned b, input int mode);
      int cyc;
      int nl, np;
      begin_walk(a, b, mode);
      check({tag, "_busy"}, {71'd0, busy}, {71'd0, (a != 0 && b != 0)});
      for (cyc = 0; cyc < 20000; cyc++) begin
         if (done) break;
         @(negedge clk);
      end
      check({tag, "_timeout"}, {71'd0, cyc < 20000}, 72'd1);
      @(negedge clk);
      check({tag, "_nleaf"}, obs_leaf.size(), exp_leaf.size());
      nl = (obs_leaf.size() < exp_leaf.size()) ? obs_leaf.size() : exp_leaf.size();
      for (int i = 0; i < nl; i++) check($sformatf("%s_leaf%0d", tag, i), obs_leaf[i], exp_leaf[i]);
      check({tag, "_npush"}, obs_push.size(), exp_push.size());
      np = (obs_push.size() < exp_push.size()) ? obs_push.size() : exp_push.size();
      for (int i = 0; i < np; i++) check($sformatf("%s_push%0d", tag, i), obs_push[i], exp_push[i]);
      check({tag, "_npop"}, obs_pops, exp_pops);
      check({tag, "_ndone"}, obs_done, 1);
      check({tag, "_idle"}, {65'd0, depth, err_overflow, busy}, 72'd0);
   endtask

   logic [63:0] k88_leaf [5] = '{{32'd4, 32'd4}, {32'd4, 32'd4}, {32'd3, 32'd3}, {32'd2, 32'd2}, {32'd4, 32'd4}};
   logic [63:0] k88_push [2] = '{{32'd4, 32'd4}, {32'd2, 32'd2}};
   logic [63:0] k83_leaf [3] = '{{32'd4, 32'd3}, {32'd3, 32'd3}, {32'd4, 32'd3}};

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cyc;
      int unsigned ra, rb;
      rst          = 1'b1;
      start        = 1'b0;
      start_size_a = '0;
      start_size_b = '0;
      s_start      = 1'b0;
      s_size_a     = '0;
      s_size_b     = '0;
      s_leaf_ready = 1'b1;
      s_leaves = 0; s_pushes = 0; s_pops = 0; s_dones = 0;
      s_first_push = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {depth, err_overflow, busy, done, leaf_valid, push, pop, leaf_size_a[0], push_size_A2[0]},
            72'd0);
      check("reset_sizes", {8'd0, leaf_size_a | leaf_size_b, push_size_A2 | push_size_B2}, 72'd0);
      rst = 1'b0;

      run_walk("w33", 3, 3, 0);
      run_walk("w88", 8, 8, 0);
      for (int i = 0; i < 5; i++) check($sformatf("w88_const_leaf%0d", i), obs_leaf[i], k88_leaf[i]);
      for (int i = 0; i < 2; i++) check($sformatf("w88_const_push%0d", i), obs_push[i], k88_push[i]);
      run_walk("w83", 8, 3, 0);
      for (int i = 0; i < 3; i++) check($sformatf("w83_const_leaf%0d", i), obs_leaf[i], k83_leaf[i]);
      run_walk("w88_stall", 8, 8, 1);

      // Overflow on the single-frame instance
      @(negedge clk);
      s_size_a = 16; s_size_b = 16; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (cyc = 0; cyc < 200; cyc++) begin
         if (s_done) break;
         @(negedge clk);
      end
      check("ovf_timeout", {71'd0, cyc < 200}, 72'd1);
      @(negedge clk);
      check("ovf_err", {71'd0, s_err}, 72'd1);
      check("ovf_done", s_dones, 1);
      check("ovf_npush", s_pushes, 1);
      check("ovf_push0", s_first_push, {32'd8, 32'd8});
      check("ovf_noleaf", s_leaves, 0);
      check("ovf_busy", {71'd0, s_busy}, 72'd0);
      s_size_a = 3; s_size_b = 3; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      check("ovf_err_cleared", {70'd0, s_err, s_busy}, 72'd1);
      for (cyc = 0; cyc < 200; cyc++) begin
         if (s_done) break;
         @(negedge clk);
      end
      @(negedge clk);
      check("ovf_after_leaf", s_leaves, 1);
      check("ovf_after_done", {s_dones[7:0], s_pops[7:0], 55'd0, s_depth}, {8'd2, 8'd0, 56'd0});

      // Reset in the middle of the third leaf
      begin_walk(8, 8, 1);
      for (cyc = 0; cyc < 500; cyc++) begin
         if (obs_leaf.size() == 2 && leaf_valid) break;
         @(negedge clk);
      end
      check("rst_reach_leaf3", {71'd0, cyc < 500}, 72'd1);
      check("rst_leaf3_size", {leaf_size_a, leaf_size_b}, {32'd3, 32'd3});
      rst = 1'b1;
      #1;
      check("rst_async_zero", {depth, err_overflow, busy, done, leaf_valid, push, pop, 58'd0}, 72'd0);
      @(posedge clk);
      #1;
      check("rst_edge_zero", {8'd0, leaf_size_a | leaf_size_b, push_size_A2 | push_size_B2}, 72'd0);
      check("rst_edge_ctrl", {depth, err_overflow, busy, done, leaf_valid, push, pop, 58'd0}, 72'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_no_done", obs_done, 0);
      run_walk("post_rst33", 3, 3, 0);
      run_walk("zero05", 0, 5, 0);

      for (int t = 0; t < 20; t++) begin
         ra = $urandom_range(0, 70);
         rb = $urandom_range(0, 70);
         if ($urandom_range(0, 9) == 0) ra = 0;
         run_walk($sformatf("rnd%0d", t), ra, rb, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
